// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for the CNN datapath: streams one stored image from the pixel ROM
// over a valid/ready handshake, then waits (with timeout) for the class result.
module cnn_frame_sequencer #(
    parameter int IX      = 28,
    parameter int IY      = 28,
    parameter int I_F_BW  = 8,
    parameter int NUM_IMG = 16,
    parameter int ADDR_BW = 14,
    parameter int SEL_BW  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [SEL_BW-1:0]  i_img_sel,
    output logic [ADDR_BW-1:0] o_mem_addr,
    input  logic [I_F_BW-1:0]  i_mem_data,
    output logic               o_pix_valid,
    output logic [I_F_BW-1:0]  o_pix_data,
    input  logic               i_pix_ready,
    input  logic               i_res_valid,
    input  logic [1:0]         i_res_class,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout,
    output logic               o_sel_err,
    output logic [2:0]         o_led
);

    localparam int PIX_N  = IX * IY;
    localparam int PIX_BW = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam int CNT_BW = $clog2(TIMEOUT + 1);

    localparam logic [PIX_BW-1:0] PIX_LAST  = PIX_BW'(PIX_N - 1);
    localparam logic [CNT_BW-1:0] CNT_LAST  = CNT_BW'(TIMEOUT - 1);
    localparam logic [SEL_BW:0]   NUM_IMG_W = (SEL_BW + 1)'(NUM_IMG);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        WAIT_RES,
        DONE
    } state_t;

    state_t             state;
    logic [PIX_BW-1:0]  pix_idx;
    logic [CNT_BW-1:0]  wait_cnt;
    logic               sel_ok;
    logic [ADDR_BW-1:0] base_addr;

    // Extra leading zero keeps the compare valid when NUM_IMG equals 2**SEL_BW.
    assign sel_ok    = {1'b0, i_img_sel} < NUM_IMG_W;
    assign base_addr = ADDR_BW'(i_img_sel) * ADDR_BW'(PIX_N);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pix_idx     <= '0;
            wait_cnt    <= '0;
            o_mem_addr  <= '0;
            o_pix_valid <= 1'b0;
            o_pix_data  <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_sel_err   <= 1'b0;
            o_led       <= 3'b000;
        end else begin
            o_done    <= 1'b0;
            o_sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (sel_ok) begin
                            state      <= FETCH;
                            o_busy     <= 1'b1;
                            o_mem_addr <= base_addr;
                            pix_idx    <= '0;
                            o_timeout  <= 1'b0;
                        end else begin
                            o_sel_err <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    o_pix_data  <= i_mem_data;
                    o_pix_valid <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    if (i_pix_ready) begin
                        o_pix_valid <= 1'b0;
                        if (pix_idx == PIX_LAST) begin
                            state    <= WAIT_RES;
                            wait_cnt <= '0;
                        end else begin
                            pix_idx    <= pix_idx + 1'b1;
                            o_mem_addr <= o_mem_addr + 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                WAIT_RES: begin
                    // A result arriving on the final counter cycle still wins over the timeout.
                    if (i_res_valid) begin
                        case (i_res_class)
                            2'd0:    o_led <= 3'b001;
                            2'd1:    o_led <= 3'b010;
                            2'd2:    o_led <= 3'b100;
                            default: o_led <= 3'b111;
                        endcase
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        o_timeout <= 1'b1;
                        o_led     <= 3'b000;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
